// File: rtl/sd_spi_engine_pkg.sv
// Shared types and constants for the SD-card SPI master engine.
package sd_spi_engine_pkg;
  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_LOW,
    SPI_HIGH,
    SPI_DONE
  } sd_spi_state_t;

  localparam logic [7:0] SD_SPI_FILL = 8'hFF;
endpackage

// File: rtl/sd_spi_clkgen.sv
// Half-period divider: pulses tick every CLK_DIV cycles while enabled.
module sd_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (clr)  div_cnt <= '0;
    else if (en)   div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
  end
endmodule

// File: rtl/sd_spi_engine.sv
// SPI mode-0 byte shifter between the mapper's SD registers and the card pins.
module sd_spi_engine
  import sd_spi_engine_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] RX_FILL = SD_SPI_FILL
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx,
  input  logic       rx,
  input  logic [7:0] data_to_SD,
  output logic [7:0] data_from_SD,
  output logic       busy,
  input  logic       ss_req,
  output logic       spi_ss,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  sd_spi_state_t state, state_nxt;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          rx_bit;
  logic          tick;

  sd_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == SPI_SETUP),
    .en      ((state == SPI_LOW) || (state == SPI_HIGH)),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SPI_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SPI_IDLE:  if (tx || rx) state_nxt = SPI_SETUP;
      SPI_SETUP: state_nxt = SPI_LOW;
      SPI_LOW:   if (tick) state_nxt = SPI_HIGH;
      SPI_HIGH:  if (tick) state_nxt = (bit_cnt == 3'd7) ? SPI_DONE : SPI_LOW;
      SPI_DONE:  state_nxt = SPI_IDLE;
      default:   state_nxt = SPI_IDLE;
    endcase
  end

  // data_from_SD only updates in DONE, so an aborted byte never leaks out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      rx_bit       <= 1'b0;
      busy         <= 1'b0;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b1;
      data_from_SD <= 8'hFF;
    end else begin
      case (state)
        SPI_IDLE: begin
          if (tx) begin
            shift_reg <= data_to_SD;
            busy      <= 1'b1;
          end else if (rx) begin
            shift_reg <= RX_FILL;
            busy      <= 1'b1;
          end
        end
        SPI_SETUP: begin
          spi_mosi <= shift_reg[7];
          bit_cnt  <= '0;
        end
        SPI_LOW: begin
          if (tick) begin
            spi_clk <= 1'b1;
            rx_bit  <= spi_miso;
          end
        end
        SPI_HIGH: begin
          if (tick) begin
            spi_clk   <= 1'b0;
            shift_reg <= {shift_reg[6:0], rx_bit};
            bit_cnt   <= bit_cnt + 3'd1;
            // shift_reg[6] becomes the MSB after this shift
            if (bit_cnt != 3'd7) spi_mosi <= shift_reg[6];
          end
        end
        SPI_DONE: begin
          data_from_SD <= shift_reg;
          busy         <= 1'b0;
          spi_mosi     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) spi_ss <= 1'b1;
    else          spi_ss <= ~ss_req;
  end
endmodule

// File: tb/tb_sd_spi_engine.sv
// Scoreboard bench for sd_spi_engine with a behavioural SPI card model.
module tb_sd_spi_engine;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx = 1'b0, rx = 1'b0, ss_req = 1'b0;
  logic [7:0] data_to_SD = 8'h00;
  logic [7:0] data_from_SD;
  logic       busy, spi_ss, spi_clk, spi_mosi, spi_miso;

  sd_spi_engine #(.CLK_DIV(D), .RX_FILL(8'hFF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx           (tx),
    .rx           (rx),
    .data_to_SD   (data_to_SD),
    .data_from_SD (data_from_SD),
    .busy         (busy),
    .ss_req       (ss_req),
    .spi_ss       (spi_ss),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Card model: presents reply MSB first, advancing after each rising spi_clk.
  int         rise_total = 0, rise_base = 0, idx;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] card_byte = 8'hFF;
  always @(posedge spi_clk) begin
    rise_total <= rise_total + 1;
    mosi_cap   <= {mosi_cap[6:0], spi_mosi};
  end
  always_comb begin
    idx      = rise_total - rise_base;
    spi_miso = (idx >= 0 && idx < 8) ? card_byte[3'(7 - idx)] : 1'b1;
  end

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] miso;
    int         cyc;
    int         base;
  } exp_t;
  exp_t exp_q[$];

  exp_t e_mon;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) prev_busy = 1'b0;
    else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          check("data_from_SD", data_from_SD, e_mon.miso);
          check("mosi_bits", mosi_cap, e_mon.mosi);
          check("sclk_rises", rise_total - e_mon.base, 8);
          check("latency", cyc - e_mon.cyc, 2 + 16 * D);
          check("idle_pins", {spi_clk, spi_mosi}, 2'b01);
        end
      end
      prev_busy = busy;
    end
  end

  // Called just after a negedge; the strobe is sampled at the next posedge.
  task automatic xfer(input logic t, input logic r, input logic [7:0] d, input logic [7:0] card);
    exp_t e;
    logic ss_exp;
    tx = t; rx = r; data_to_SD = d;
    card_byte = card;
    rise_base = rise_total;
    ss_req = 1'($urandom);
    @(negedge clk);
    tx = 1'b0; rx = 1'b0; data_to_SD = 8'($urandom);
    ss_exp = ~ss_req;
    check("busy_rise", busy, 1);
    check("spi_ss", spi_ss, ss_exp);
    e.mosi = t ? d : 8'hFF;
    e.miso = card;
    e.cyc  = cyc;
    e.base = rise_base;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_spi_clk", spi_clk, 0);
    check("rst_spi_mosi", spi_mosi, 1);
    check("rst_spi_ss", spi_ss, 1);
    check("rst_busy", busy, 0);
    check("rst_data", data_from_SD, 8'hFF);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic t, r;
    bit ok;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals();

    // directed: tx A5 with reply 3C, rx with reply 01, tx+rx collision
    xfer(1'b1, 1'b0, 8'hA5, 8'h3C); wait_idle();
    xfer(1'b0, 1'b1, 8'h5A, 8'h01); wait_idle();
    xfer(1'b1, 1'b1, 8'h40, 8'($urandom)); wait_idle();

    // strobe while busy is dropped; strobe in first idle cycle is taken
    r0 = rise_total;
    xfer(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    repeat (20) @(negedge clk);
    tx = 1'b1; data_to_SD = 8'h00;
    @(negedge clk);
    tx = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) check("busy_fall_timeout", 0, 1);
    xfer(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    wait_idle();
    check("b2b_pulses", rise_total - r0, 16);

    // random traffic
    for (int n = 0; n < 8; n++) begin
      t = 1'($urandom);
      r = 1'($urandom);
      if (!t && !r) r = 1'b1;
      xfer(t, r, 8'($urandom), 8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // async reset after 3 bits aborts the byte
    xfer(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rise_total - rise_base >= 3) ok = 1'b1;
    end
    if (!ok) check("bit3_timeout", 0, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sd_spi_engine.md
Name: sd_spi_engine

Overview:
- SPI-master end of ext_sd_card_if: implements the SD_mp side of that interface and drives spi_if pins toward the SD card.
- Takes one-cycle tx/rx strobes plus a byte from a cartridge device (MFRSD-style mapper), shifts one byte full-duplex in SPI mode 0, and presents the received byte on data_from_SD.
- Sits between the mapper's SD register logic and the top-level SD pins.

Parameters:
- CLK_DIV, 4, system clocks per SPI half-period. Legal range 1..255.
- RX_FILL, 8'hFF, byte driven on MOSI during an rx (read) transfer.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tx  input  1  one-cycle strobe: send data_to_SD
- rx  input  1  one-cycle strobe: send RX_FILL, capture reply
- data_to_SD  input  8  byte to transmit, sampled on the tx strobe cycle
- data_from_SD  output  8  last byte received from the card
- busy  output  1  transfer in progress
- ss_req  input  1  chip-select request from the device (1 = selected)
- spi_ss  output  1  active-low card select, registered inverse of ss_req
- spi_clk  output  1  SPI clock, idle low
- spi_mosi  output  1  serial data to card, MSB first
- spi_miso  input  1  serial data from card

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; spi_clk=0; spi_mosi=1; spi_ss=1; busy=0; data_from_SD=8'hFF; counters 0.
  - Reset mid-transfer aborts immediately. No partial byte is ever written to data_from_SD.
- States:
  - IDLE:
    - On tx: shift_reg<=data_to_SD. On rx: shift_reg<=RX_FILL.
    - tx and rx asserted in the same cycle: tx wins.
    - Next state SETUP; busy=1 from the following cycle.
  - SETUP: spi_mosi<=shift_reg[7]; div_cnt<=0; bit_cnt<=0; next LOW.
  - LOW: spi_clk=0, held CLK_DIV cycles. At expiry: spi_clk<=1, sample spi_miso into rx_bit; next HIGH.
  - HIGH: spi_clk=1, held CLK_DIV cycles. At expiry:
    - spi_clk<=0; shift_reg<={shift_reg[6:0], rx_bit}; bit_cnt++.
    - If bit_cnt was 7: next DONE. Else spi_mosi<=next bit and next LOW.
  - DONE (one cycle): data_from_SD<=shift_reg; busy<=0; spi_mosi<=1; next IDLE.
- Timing:
  - Strobe to busy fall = 2 + 16*CLK_DIV cycles.
  - data_from_SD is valid in the same cycle busy falls.
  - A new strobe is accepted in the first cycle busy=0.
- Strobes while busy=1 are ignored. No queueing; the caller must poll busy.
- tx transfers also capture MISO into data_from_SD (full duplex).
- spi_ss:
  - Registered from ~ss_req every cycle, independent of the FSM.
  - Changing ss_req mid-byte is allowed and does not stop the shifter.
- Counters:
  - div_cnt is 8 bits and wraps to 0 at CLK_DIV-1.
  - bit_cnt is 3 bits; wrap from 7 ends the transfer.
- spi_clk is a registered output, glitch-free. Mode 0: CPOL=0, CPHA=0.

Decomposition:
- Shared package:
  - Enum sd_spi_state_t {SPI_IDLE, SPI_SETUP, SPI_LOW, SPI_HIGH, SPI_DONE}.
  - Constant SD_SPI_FILL = 8'hFF, used as the RX_FILL default.
- One sub-module sd_spi_clkgen:
  - Half-period divider producing a `tick` pulse every CLK_DIV cycles while enabled.
  - Cleared on SETUP.
  - The FSM stays in the top module.

Test Plan:
- Reset release with no strobes -> spi_clk=0, spi_mosi=1, spi_ss=1, busy=0, data_from_SD=8'hFF.
- CLK_DIV=4, tx with data_to_SD=8'hA5, card model returns 8'h3C -> MOSI shows 1,0,1,0,0,1,0,1 sampled on rising spi_clk. Exactly 8 rising edges. busy falls 66 cycles after the strobe with data_from_SD=8'h3C.
- rx strobe, card returns 8'h01 -> MOSI constant 1 for all 8 bits; data_from_SD=8'h01 when busy falls.
- tx and rx in the same cycle with data_to_SD=8'h40 -> MOSI carries 8'h40, not 8'hFF.
- Strobe during busy, then strobe in the first cycle busy=0 -> first extra strobe has no effect; second starts a new transfer. Back-to-back transfers produce 16 total spi_clk pulses.
- reset_n low after 3 bits of a transfer -> outputs return to reset values asynchronously; data_from_SD remains 8'hFF; the next tx completes normally.
